// File: rtl/sram_req_arb_pkg.sv
// rtl/sram_req_arb_pkg.sv - shared encodings for the SRAM-like request arbiter
//
// Purpose: source IDs carried through the order FIFO, arbiter FSM state
// encoding and the packed request payload shared with the AXI bridge.
// Ports: none (package).

package sram_req_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

  // Field order matches the {wr, size, addr, wstrb, wdata} port grouping.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_order_fifo.sv
// rtl/sram_order_fifo.sv - order FIFO recording which requester owns each outstanding beat
//
// Purpose: small circular FIFO; simultaneous push and pop keeps count and
// advances both pointers, which wrap modulo DEPTH (DEPTH is a power of two).
// Ports:
//   aclk, areset        clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write one entry (ignored when full)
//   pop, pop_data       consume head entry (ignored when empty); pop_data is the head
//   full, empty, count  occupancy status

module sram_order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arb.sv
// rtl/sram_req_arb.sv - arbitrates inst and data SRAM-like requests onto one downstream port
//
// Purpose: grants one requester per cycle (data preferred unless inst has
// been starved STARVE_MAX times), holds the granted payload until accepted,
// and routes in-order responses back using an order FIFO.
// Ports:
//   aclk, areset                       clock, synchronous active-high reset
//   inst_* / data_*                    requester request inputs, addr_ok/data_ok/rdata outputs
//   m_req, m_wr .. m_wdata             downstream request (combinational in grant cycle)
//   m_addr_ok, m_data_ok, m_rdata      downstream handshake and in-order response
//   err_unexpected                     sticky: response beat seen with nothing outstanding

module sram_req_arb
  import sram_req_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_unexpected
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e      state_q, state_d;
  sram_req_t       hold_q, hold_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            err_q, err_d;

  sram_req_t       inst_pl, data_pl, grant_pl;
  logic            grant_v, grant_src, accept, beat_ok, head_ok;
  logic            fifo_full, fifo_empty, head_src;
  logic [CW-1:0]   fifo_count;

  assign inst_pl = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
  assign data_pl = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ARB_IDLE;
      hold_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    starve_d = starve_q;
    err_d    = err_q | (m_data_ok & fifo_empty);
    case (state_q)
      ARB_IDLE: begin
        if (grant_v && !m_addr_ok) begin
          state_d = (grant_src == SRC_INST) ? ARB_HOLD_I : ARB_HOLD_D;
          hold_d  = grant_pl;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (m_addr_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (inst_addr_ok) begin
      starve_d = '0;
    end else if (data_addr_ok && inst_req && (starve_q < SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Output logic; everything is forced low while areset is high
  always_comb begin
    grant_v   = 1'b0;
    grant_src = SRC_INST;
    grant_pl  = '0;
    case (state_q)
      ARB_IDLE: begin
        // A pop in this cycle does not free a slot until the next one.
        if (!fifo_full) begin
          if (data_req && (starve_q < SW'(STARVE_MAX))) begin
            grant_v = 1'b1; grant_src = SRC_DATA; grant_pl = data_pl;
          end else if (inst_req) begin
            grant_v = 1'b1; grant_src = SRC_INST; grant_pl = inst_pl;
          end else if (data_req) begin
            grant_v = 1'b1; grant_src = SRC_DATA; grant_pl = data_pl;
          end
        end
      end
      ARB_HOLD_I: begin
        grant_v = 1'b1; grant_src = SRC_INST; grant_pl = hold_q;
      end
      ARB_HOLD_D: begin
        grant_v = 1'b1; grant_src = SRC_DATA; grant_pl = hold_q;
      end
      default: grant_v = 1'b0;
    endcase
    if (areset) begin
      grant_v  = 1'b0;
      grant_pl = '0;
    end
    accept       = grant_v & m_addr_ok;
    inst_addr_ok = accept & (grant_src == SRC_INST);
    data_addr_ok = accept & (grant_src == SRC_DATA);
    head_ok      = ~areset & ~fifo_empty;
    beat_ok      = head_ok & m_data_ok;
    inst_data_ok = beat_ok & (head_src == SRC_INST);
    data_data_ok = beat_ok & (head_src == SRC_DATA);
    inst_rdata   = (head_ok && head_src == SRC_INST) ? m_rdata : '0;
    data_rdata   = (head_ok && head_src == SRC_DATA) ? m_rdata : '0;
    m_req        = grant_v;
    {m_wr, m_size, m_addr, m_wstrb, m_wdata} = grant_pl;
  end

  assign err_unexpected = err_q;

  sram_order_fifo #(.DEPTH(DEPTH), .W(1)) u_order_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (accept),
    .push_data (grant_src),
    .pop       (beat_ok),
    .pop_data  (head_src),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_full_matches_count: assert property (@(posedge aclk) disable iff (areset)
    fifo_full == (fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_sram_req_arb.sv
// tb/tb_sram_req_arb.sv - self-checking bench for sram_req_arb

module tb_sram_req_arb;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, err_unexpected;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always #5 aclk = ~aclk;

  sram_req_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_unexpected(err_unexpected)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of outstanding owners, pending (unaccepted) grant, starvation count.
  int          q[$];
  bit          hold_v = 0;
  bit          hold_src = 0;
  logic [70:0] hold_pl = '0;
  int          starve = 0;
  bit          err_m = 0;

  logic        obs_m_req, obs_inst_aok, obs_data_aok, obs_inst_dok, obs_data_dok, obs_err;
  logic [31:0] obs_m_addr, obs_inst_rdata, obs_data_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [70:0] ipl, dpl, gpl;
    bit gv, gs, acc, hv, hs;
    @(negedge aclk);
    obs_m_req = m_req; obs_m_addr = m_addr; obs_err = err_unexpected;
    obs_inst_aok = inst_addr_ok; obs_data_aok = data_addr_ok;
    obs_inst_dok = inst_data_ok; obs_data_dok = data_data_ok;
    obs_inst_rdata = inst_rdata; obs_data_rdata = data_rdata;
    ipl = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
    dpl = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
    gv = 0; gs = 0; gpl = '0;
    if (!areset) begin
      if (hold_v) begin
        gv = 1; gs = hold_src; gpl = hold_pl;
      end else if (q.size() < DEPTH) begin
        if (data_req && starve < STARVE_MAX) begin gv = 1; gs = 1; gpl = dpl; end
        else if (inst_req)                   begin gv = 1; gs = 0; gpl = ipl; end
        else if (data_req)                   begin gv = 1; gs = 1; gpl = dpl; end
      end
    end
    acc = gv && m_addr_ok;
    hv  = !areset && q.size() > 0;
    hs  = hv ? bit'(q[0]) : 1'b0;
    check("m_req", 128'(m_req), 128'(gv));
    check("m_payload", 128'({m_wr, m_size, m_addr, m_wstrb, m_wdata}), 128'(gpl));
    check("inst_addr_ok", 128'(inst_addr_ok), 128'(acc && !gs));
    check("data_addr_ok", 128'(data_addr_ok), 128'(acc && gs));
    check("inst_data_ok", 128'(inst_data_ok), 128'(hv && m_data_ok && !hs));
    check("data_data_ok", 128'(data_data_ok), 128'(hv && m_data_ok && hs));
    check("inst_rdata", 128'(inst_rdata), 128'((hv && !hs) ? m_rdata : 32'h0));
    check("data_rdata", 128'(data_rdata), 128'((hv && hs) ? m_rdata : 32'h0));
    if (!areset) check("err_unexpected", 128'(err_unexpected), 128'(err_m));
    if (areset) begin
      q.delete(); hold_v = 0; starve = 0; err_m = 0;
    end else begin
      if (acc && !gs) starve = 0;
      else if (acc && gs && inst_req && starve < STARVE_MAX) starve++;
      if (m_data_ok) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1;
      end
      if (acc) q.push_back(int'(gs));
      if (gv && !m_addr_ok) begin hold_v = 1; hold_src = gs; hold_pl = gpl; end
      else hold_v = 0;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic set_idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h100; inst_wstrb = 4'hf; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h200; data_wstrb = 4'hf; data_wdata = 32'h0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 32'h0;
  endtask

  task automatic do_reset();
    set_idle();
    areset = 1;
    step();
    step();
    areset = 0;
  endtask

  task automatic rand_inputs();
    inst_req = ($urandom_range(0, 9) < 6); inst_wr = 1'($urandom); inst_size = 2'($urandom);
    inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
    data_req = ($urandom_range(0, 9) < 6); data_wr = 1'($urandom); data_size = 2'($urandom);
    data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
    m_addr_ok = ($urandom_range(0, 9) < 7);
    m_data_ok = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 63) == 0);
    m_rdata = $urandom;
    areset = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int n_inst;
    bit first_data;

    // Reset state
    do_reset();
    step();
    check("reset_m_req", 128'(obs_m_req), 128'(0));
    check("reset_err", 128'(obs_err), 128'(0));

    // Contention: both requesting, data wins first, inst within 5 grants
    do_reset();
    inst_req = 1; data_req = 1; m_addr_ok = 1; data_addr = 32'h3000;
    n_inst = 0; first_data = 0;
    for (int i = 0; i < 5; i++) begin
      m_data_ok = (q.size() > 0); m_rdata = $urandom;
      step();
      if (i == 0) first_data = obs_data_aok;
      if (obs_inst_aok) n_inst++;
    end
    check("cont_first_data", 128'(first_data), 128'(1));
    check("cont_inst_by5", 128'(n_inst), 128'(1));

    // Backpressure: payload held while requester changes
    do_reset();
    data_req = 1; data_addr = 32'h1000;
    step();
    check("bp_addr0", 128'(obs_m_addr), 128'(32'h1000));
    data_addr = 32'h2000;
    step();
    check("bp_addr1", 128'(obs_m_addr), 128'(32'h1000));
    step();
    check("bp_addr2", 128'(obs_m_addr), 128'(32'h1000));
    m_addr_ok = 1;
    step();
    check("bp_accept_addr", 128'(obs_m_addr), 128'(32'h1000));
    check("bp_accept_ok", 128'(obs_data_aok), 128'(1));

    // Full: four outstanding blocks the fifth, pop frees a slot next cycle
    do_reset();
    inst_req = 1; m_addr_ok = 1;
    for (int i = 0; i < 4; i++) step();
    step();
    check("full_block", 128'(obs_m_req), 128'(0));
    m_data_ok = 1; m_rdata = 32'h55;
    step();
    check("full_pop_same", 128'(obs_m_req), 128'(0));
    check("full_pop_dok", 128'(obs_inst_dok), 128'(1));
    m_data_ok = 0;
    step();
    check("full_regrant", 128'(obs_m_req), 128'(1));

    // Ordering: inst, data, inst responses routed in order
    do_reset();
    m_addr_ok = 1;
    inst_req = 1; step();
    inst_req = 0; data_req = 1; step();
    data_req = 0; inst_req = 1; step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    m_rdata = 32'hAAAA_0001; step();
    check("ord_a_ok", 128'(obs_inst_dok), 128'(1));
    check("ord_a_data", 128'(obs_inst_rdata), 128'(32'hAAAA_0001));
    m_rdata = 32'hBBBB_0002; step();
    check("ord_b_ok", 128'(obs_data_dok), 128'(1));
    check("ord_b_data", 128'(obs_data_rdata), 128'(32'hBBBB_0002));
    m_rdata = 32'hCCCC_0003; step();
    check("ord_c_ok", 128'(obs_inst_dok), 128'(1));
    check("ord_c_data", 128'(obs_inst_rdata), 128'(32'hCCCC_0003));
    m_data_ok = 0;

    // Unexpected response: ignored, sticky error until reset
    do_reset();
    m_data_ok = 1; m_rdata = 32'hDEAD;
    step();
    check("err_no_dok", 128'(obs_inst_dok | obs_data_dok), 128'(0));
    m_data_ok = 0;
    step();
    check("err_set", 128'(obs_err), 128'(1));
    for (int i = 0; i < 3; i++) step();
    check("err_sticky", 128'(obs_err), 128'(1));
    do_reset();
    step();
    check("err_cleared", 128'(obs_err), 128'(0));

    // Reset with two outstanding discards them
    do_reset();
    inst_req = 1; m_addr_ok = 1;
    step(); step();
    areset = 1; step();
    areset = 0; set_idle();
    step();
    check("rst_m_req", 128'(obs_m_req), 128'(0));
    m_data_ok = 1;
    step();
    check("rst_discard", 128'(obs_inst_dok), 128'(0));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
